// File: rtl/core_wb_sched.sv
// rtl/core_wb_sched.sv - writeback scheduler: four result producers onto two register-file write ports
// Define CORE_WB_SCHED_DUAL_EN for two grants per cycle; otherwise one grant per cycle on port A only.
module core_wb_sched #(
  parameter int MAX_WAIT = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req_valid,
  input  logic [3:0][3:0]  req_reg,
  input  logic [3:0][31:0] req_value,
  output logic [3:0]       req_ready,
  output logic             wr_a_en,
  output logic [3:0]       wr_a_reg,
  output logic [31:0]      wr_a_value,
  output logic             wr_b_en,
  output logic [3:0]       wr_b_reg,
  output logic [31:0]      wr_b_value,
  output logic [15:0]      pending
);

  localparam logic [2:0] WAIT_MAX = 3'(MAX_WAIT);

  logic [1:0]      rr;
  logic [3:0][2:0] wait_cnt;
  logic [3:0]      urgent;
  logic            sel_a_vld;
  logic            sel_b_vld;
  logic [1:0]      sel_a;
  logic [1:0]      sel_b;

  always_comb begin
    urgent = '0;
    for (int i = 0; i < 4; i++) begin
      urgent[i] = req_valid[i] && (wait_cnt[i] == WAIT_MAX);
    end
  end

  // Eight candidate slots: urgent sources by index, then non-urgent valid sources from rr onward.
  always_comb begin
    logic [1:0] idx;
    logic       cand;
    idx       = '0;
    cand      = 1'b0;
    sel_a_vld = 1'b0;
    sel_a     = '0;
    sel_b_vld = 1'b0;
    sel_b     = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        idx  = 2'(k);
        cand = urgent[idx];
      end else begin
        idx  = rr + 2'(k - 4);
        cand = req_valid[idx] && !urgent[idx];
      end
      if (cand) begin
        if (!sel_a_vld) begin
          sel_a_vld = 1'b1;
          sel_a     = idx;
        end
`ifdef CORE_WB_SCHED_DUAL_EN
        // A second write to the same register would race the first in the regfile.
        else if (!sel_b_vld && (req_reg[idx] != req_reg[sel_a])) begin
          sel_b_vld = 1'b1;
          sel_b     = idx;
        end
`endif
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n) begin
      if (sel_a_vld) req_ready[sel_a] = 1'b1;
      if (sel_b_vld) req_ready[sel_b] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr         <= '0;
      wait_cnt   <= '0;
      wr_a_en    <= 1'b0;
      wr_a_reg   <= '0;
      wr_a_value <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && !req_ready[i]) begin
          wait_cnt[i] <= (wait_cnt[i] == WAIT_MAX) ? wait_cnt[i] : wait_cnt[i] + 3'd1;
        end else begin
          wait_cnt[i] <= '0;
        end
      end
      if (sel_b_vld) begin
        rr <= sel_b + 2'd1;
      end else if (sel_a_vld) begin
        rr <= sel_a + 2'd1;
      end
      wr_a_en    <= sel_a_vld;
      wr_a_reg   <= sel_a_vld ? req_reg[sel_a] : 4'd0;
      wr_a_value <= sel_a_vld ? req_value[sel_a] : 32'd0;
    end
  end

`ifdef CORE_WB_SCHED_DUAL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_b_en    <= 1'b0;
      wr_b_reg   <= '0;
      wr_b_value <= '0;
    end else begin
      wr_b_en    <= sel_b_vld;
      wr_b_reg   <= sel_b_vld ? req_reg[sel_b] : 4'd0;
      wr_b_value <= sel_b_vld ? req_value[sel_b] : 32'd0;
    end
  end
`else
  assign wr_b_en    = 1'b0;
  assign wr_b_reg   = '0;
  assign wr_b_value = '0;
`endif

  always_comb begin
    pending = '0;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i]) pending[req_reg[i]] = 1'b1;
    end
    if (wr_a_en) pending[wr_a_reg] = 1'b1;
    if (wr_b_en) pending[wr_b_reg] = 1'b1;
  end

endmodule

// File: tb/tb_core_wb_sched.sv
// tb/tb_core_wb_sched.sv - self-checking bench for core_wb_sched (honours CORE_WB_SCHED_DUAL_EN)
module tb_core_wb_sched;

  localparam int MW = 2;
`ifdef CORE_WB_SCHED_DUAL_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       valid = '0;
  logic [3:0][3:0]  regs = '0;
  logic [3:0][31:0] vals = '0;
  logic [3:0]       req_ready;
  logic             wr_a_en, wr_b_en;
  logic [3:0]       wr_a_reg, wr_b_reg;
  logic [31:0]      wr_a_value, wr_b_value;
  logic [15:0]      pending;

  core_wb_sched #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(valid), .req_reg(regs), .req_value(vals),
    .req_ready(req_ready),
    .wr_a_en(wr_a_en), .wr_a_reg(wr_a_reg), .wr_a_value(wr_a_value),
    .wr_b_en(wr_b_en), .wr_b_reg(wr_b_reg), .wr_b_value(wr_b_value),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  int          m_rr;
  int          m_wait [4];
  logic        m_wa_en, m_wb_en;
  logic [3:0]  m_wa_reg, m_wb_reg;
  logic [31:0] m_wa_val, m_wb_val;
  logic [3:0]  g_last;

  task automatic model_reset();
    m_rr = 0;
    foreach (m_wait[i]) m_wait[i] = 0;
    m_wa_en = 0; m_wa_reg = 0; m_wa_val = 0;
    m_wb_en = 0; m_wb_reg = 0; m_wb_val = 0;
    g_last = '0;
  endtask

  task automatic model_pick(output logic [3:0] g, output int a, output int b);
    int order[$];
    g = '0; a = -1; b = -1;
    for (int i = 0; i < 4; i++)
      if (valid[i] && m_wait[i] == MW) order.push_back(i);
    for (int j = 0; j < 4; j++) begin
      int s;
      s = (m_rr + j) % 4;
      if (valid[s] && m_wait[s] != MW) order.push_back(s);
    end
    foreach (order[k]) begin
      if (a < 0) a = order[k];
      else if (DUAL && b < 0 && regs[order[k]] != regs[a]) b = order[k];
    end
    if (a >= 0) g[a] = 1'b1;
    if (b >= 0) g[b] = 1'b1;
  endtask

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (valid[i]) p |= 16'(1) << regs[i];
    if (m_wa_en) p |= 16'(1) << m_wa_reg;
    if (m_wb_en) p |= 16'(1) << m_wb_reg;
    return p;
  endfunction

  task automatic model_commit(input logic [3:0] g, input int a, input int b);
    m_wa_en  = (a >= 0);
    m_wa_reg = (a >= 0) ? regs[a] : 4'd0;
    m_wa_val = (a >= 0) ? vals[a] : 32'd0;
    m_wb_en  = (b >= 0);
    m_wb_reg = (b >= 0) ? regs[b] : 4'd0;
    m_wb_val = (b >= 0) ? vals[b] : 32'd0;
    for (int i = 0; i < 4; i++)
      m_wait[i] = (valid[i] && !g[i]) ? ((m_wait[i] + 1 > MW) ? MW : m_wait[i] + 1) : 0;
    if (b >= 0) m_rr = (b + 1) % 4;
    else if (a >= 0) m_rr = (a + 1) % 4;
  endtask

  task automatic step();
    logic [3:0] g;
    int a, b;
    @(negedge clk);
    model_pick(g, a, b);
    chk("rnd_ready", 32'(req_ready), 32'(g));
    chk("rnd_pending", 32'(pending), 32'(model_pending()));
    chk("rnd_wa", {wr_a_en, 27'd0, wr_a_reg}, {m_wa_en, 27'd0, m_wa_reg});
    chk("rnd_wa_val", wr_a_value, m_wa_val);
    chk("rnd_wb", {wr_b_en, 27'd0, wr_b_reg}, {m_wb_en, 27'd0, m_wb_reg});
    chk("rnd_wb_val", wr_b_value, m_wb_val);
    g_last = g;
    @(posedge clk);
    model_commit(g, a, b);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = '0; regs = '0; vals = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [15:0] r;
    logic [3:0]  es;
    logic [3:0]  ed;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [3:0]  ex;
    logic [15:0] pexp;
    int          lo, hi, maxc;
    int          consec [3];

    tbl[0] = '{4'b0001, 16'h0003, 4'b0001, 4'b0001};
    tbl[1] = '{4'b1111, 16'h4321, 4'b0001, 4'b0011};
    tbl[2] = '{4'b0011, 16'h0055, 4'b0001, 4'b0001};
    tbl[3] = '{4'b0111, 16'h0655, 4'b0001, 4'b0101};
    tbl[4] = '{4'b1100, 16'h5500, 4'b0100, 4'b0100};
    tbl[5] = '{4'b0000, 16'h1234, 4'b0000, 4'b0000};
    tbl[6] = '{4'b1010, 16'h9080, 4'b0010, 4'b1010};
    tbl[7] = '{4'b1000, 16'hF000, 4'b1000, 4'b1000};
    tbl[8] = '{4'b1111, 16'h7777, 4'b0001, 4'b0001};

    // Reset state
    rst_n = 1'b0;
    valid = 4'b0100; regs[2] = 4'd11;
    #3;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_ports", {wr_a_en, wr_b_en, wr_a_reg, wr_b_reg}, 32'd0);
    chk("reset_values", wr_a_value | wr_b_value, 32'd0);
    chk("reset_pending", 32'(pending), 32'h0800);

    // Single-cycle vectors from a fresh reset (rr=0, no waiting)
    for (int k = 0; k < 9; k++) begin
      do_reset();
      valid = tbl[k].v;
      regs  = tbl[k].r;
      for (int i = 0; i < 4; i++) vals[i] = 32'h12345678 + 32'h11111111 * i + k;
      ex = DUAL ? tbl[k].ed : tbl[k].es;
      lo = 0; hi = 0;
      for (int i = 3; i >= 0; i--) if (ex[i]) lo = i;
      for (int i = 0; i < 4; i++) if (ex[i]) hi = i;
      pexp = '0;
      for (int i = 0; i < 4; i++) if (tbl[k].v[i]) pexp |= 16'(1) << regs[i];
      @(negedge clk);
      chk($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(ex));
      chk($sformatf("vec%0d_pend0", k), 32'(pending), 32'(pexp));
      @(posedge clk); #1;
      valid = tbl[k].v & ~ex;
      pexp = '0;
      for (int i = 0; i < 4; i++) if (valid[i]) pexp |= 16'(1) << regs[i];
      if (ex != 0) pexp |= 16'(1) << regs[lo];
      if ($countones(ex) == 2) pexp |= 16'(1) << regs[hi];
      @(negedge clk);
      chk($sformatf("vec%0d_wa", k), {wr_a_en, 27'd0, wr_a_reg},
          {(ex != 0), 27'd0, (ex != 0) ? regs[lo] : 4'd0});
      chk($sformatf("vec%0d_wa_val", k), wr_a_value, (ex != 0) ? vals[lo] : 32'd0);
      chk($sformatf("vec%0d_wb", k), {wr_b_en, 27'd0, wr_b_reg},
          {($countones(ex) == 2), 27'd0, ($countones(ex) == 2) ? regs[hi] : 4'd0});
      chk($sformatf("vec%0d_pend1", k), 32'(pending), 32'(pexp));
      if (ex == tbl[k].v) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk($sformatf("vec%0d_pend2", k), {15'd0, wr_a_en, pending}, 32'd0);
      end
    end

    // All four valid: rr rotation across two cycles
    do_reset();
    valid = 4'b1111; regs = 16'h4321;
    @(negedge clk);
    chk("rr_cycle0", 32'(req_ready), DUAL ? 32'b0011 : 32'b0001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rr_cycle1", 32'(req_ready), DUAL ? 32'b1100 : 32'b0010);
    chk("rr_cycle1_wa", 32'(wr_a_reg), 32'd1);

    // Same register on mul and ldst with rr=2: mul first, ldst next, in order
    do_reset();
    valid = 4'b0010; regs[1] = 4'd7;
    @(negedge clk);
    chk("conf_pre", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    valid = 4'b1100; regs[2] = 4'd5; regs[3] = 4'd5;
    vals[2] = 32'hAAAA0002; vals[3] = 32'hBBBB0003;
    @(negedge clk);
    chk("conf_c0_ready", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    valid = 4'b1000;
    @(negedge clk);
    chk("conf_c1_ready", 32'(req_ready), 32'b1000);
    chk("conf_c1_wa_val", wr_a_value, 32'hAAAA0002);
    chk("conf_c1_wb_en", 32'(wr_b_en), 32'd0);
    @(posedge clk); #1;
    valid = 4'b0000;
    @(negedge clk);
    chk("conf_c2_wa", {wr_a_en, 27'd0, wr_a_reg}, {1'b1, 27'd0, 4'd5});
    chk("conf_c2_wa_val", wr_a_value, 32'hBBBB0003);

    // Starvation bound with three continuous requesters
    do_reset();
    valid = 4'b0111; regs = 16'h0621;
    maxc = 0;
    foreach (consec[i]) consec[i] = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        consec[i] = req_ready[i] ? 0 : consec[i] + 1;
        if (consec[i] > maxc) maxc = consec[i];
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) if (req_ready[i] || 1'b1) vals[i] = vals[i] + 1;
    end
    chk("starve_max_le_mw", 32'(maxc <= MW), 32'd1);

    // Asynchronous reset mid-cycle while a write is on port A
    do_reset();
    valid = 4'b0001; regs[0] = 4'd3; vals[0] = 32'hCAFE0001;
    @(posedge clk); #1;
    valid = 4'b0100; regs[2] = 4'd9;
    #2;
    chk("arst_pre_wa_en", 32'(wr_a_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_ports", {wr_a_en, wr_b_en, wr_a_reg, wr_b_reg}, 32'd0);
    chk("arst_value", wr_a_value, 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_pending", 32'(pending), 32'h0200);
    #1 rst_n = 1'b1;
    valid = 4'b1111; regs = 16'h4321;
    #1;
    chk("arst_rr_restart", 32'(req_ready), DUAL ? 32'b0011 : 32'b0001);
    @(posedge clk); #1;
    valid = '0;

    // Randomized traffic against the reference model
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        for (int i = 0; i < 4; i++) begin
          if (!valid[i] || g_last[i]) begin
            valid[i] = ($urandom % 4) != 0;
            regs[i]  = 4'($urandom_range(0, 5));
            vals[i]  = $urandom;
          end
        end
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
